// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch stage and the stack-machine execute core.
// Opcode values are fixed by the core's decoder.
package cpu_pkg;

  localparam int WORD_W = 16;
  localparam int ENTRY_W = 2 * WORD_W;
  localparam logic [WORD_W-1:0] RESET_PC_DFLT = 16'h0000;

  typedef enum logic [WORD_W-1:0] {
    IGN  = 16'h0000, LIT  = 16'h0001, DUP  = 16'h0002, DRP  = 16'h0003,
    SWP  = 16'h0004, OVR  = 16'h0005, ADD  = 16'h0006, SUB  = 16'h0007,
    MUL  = 16'h0008, DIV  = 16'h0009, AND  = 16'h000a, ORR  = 16'h000b,
    XOR  = 16'h000c, SHL  = 16'h000d, SHR  = 16'h000e, LDM  = 16'h000f,
    STM  = 16'h0010, JMP  = 16'h0011, BRA  = 16'h0012, BEC  = 16'h0013,
    CALL = 16'h0014, RET  = 16'h0015, HLT  = 16'h0016, NOT  = 16'h0017
  } opcode_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer; head data is combinational, push/pop/flush act at the clock edge.
// Flush and reset override push/pop; simultaneous push and pop is legal when full.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clock) disable iff (reset || flush)
                                (push && !pop) |-> (count != FULL));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives the sync ROM, queues {pc, word} pairs, hands them to the core via valid/ready.
// First word valid 2 cycles after reset/+3 after redirect; issue stalls once queue plus in-flight reach DEPTH. Option macro: FETCH_PERF_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [15:0] RESET_PC = RESET_PC_DFLT
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] address_rom,
  input  logic [15:0] q_rom,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  logic [15:0]   fetch_pc;
  logic [15:0]   req_pc;
  logic          req_valid;
  logic [15:0]   hold_instr;
  logic [15:0]   hold_pc;
  logic [AW:0]   count;
  logic [AW+1:0] occupancy;
  logic          issue;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  tail;

  // The in-flight word already owns a slot, so it counts toward occupancy.
  assign occupancy   = {1'b0, count} + {{(AW+1){1'b0}}, req_valid};
  assign issue       = !redirect && (occupancy < DEPTH_W);
  assign push        = req_valid && !redirect;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign tail        = '{pc: req_pc, word: q_rom};
  assign address_rom = fetch_pc;
  assign instr       = instr_valid ? head.word : hold_instr;
  assign instr_pc    = instr_valid ? head.pc   : hold_pc;

  fetch_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (tail),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      req_valid  <= 1'b0;
      req_pc     <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      if (redirect)   fetch_pc <= redirect_pc;
      else if (issue) fetch_pc <= fetch_pc + 16'd1;
      req_valid <= issue;
      if (issue) req_pc <= fetch_pc;
      if (instr_valid) begin
        hold_instr <= head.word;
        hold_pc    <= head.pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 16'd1;
      if (instr_ready && !instr_valid) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: the expected stream is consecutive pcs from the last reset/redirect target.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address_rom;
  logic [15:0] q_rom = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall;
  logic [15:0] stall0;
`endif

  logic [15:0]  rom [65536];
  fetch_entry_t exp_q [$];
  logic [15:0]  exp_tail;
  int           vectors = 0;
  int           miscompares = 0;
  logic         prev_hold = 1'b0;
  logic [15:0]  prev_pc = '0;

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .address_rom (address_rom),
    .q_rom       (q_rom),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous ROM: data for the address seen at an edge appears just after it.
  always @(posedge clock) q_rom <= rom[address_rom];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 32) begin
      exp_q.push_back('{pc: exp_tail, word: rom[exp_tail]});
      exp_tail = exp_tail + 16'd1;
    end
  endtask

  task automatic load_expect(input logic [15:0] pc);
    exp_q.delete();
    exp_tail = pc;
    top_up();
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    top_up();
  endtask

  // Leaves the bench at cycle 0 (first cycle with reset low).
  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    redirect = 1'b0;
    instr_ready = rdy;
    exp_q.delete();
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b0;
    load_expect(16'h0000);
  endtask

  // Monitor: pops the scoreboard on every accepted handshake, and checks the head never vanishes.
  always @(negedge clock) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("valid_held", 32'({instr_valid, instr_pc}), 32'({1'b1, prev_pc}));
      if (instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard_empty: got pc %h, expected no delivery", instr_pc);
        end else begin
          fetch_entry_t e;
          e = exp_q.pop_front();
          check("instr_pc", 32'(instr_pc), 32'(e.pc));
          check("instr", 32'(instr), 32'(e.word));
        end
      end
      prev_hold = instr_valid && !instr_ready && !redirect;
      prev_pc   = instr_pc;
    end
  end

  initial begin
    logic [15:0] rp;
    int rst_cnt;
    for (int i = 0; i < 65536; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h0001; rom[1] = 16'h0005; rom[2] = 16'h000b; rom[3] = 16'h0000;

    // Reset release and first-word latency with ready high.
    do_reset(1'b1);
    #3;
    check("rst_address_rom", 32'(address_rom), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_instr_pc", 32'(instr_pc), 32'h0);
    cyc(); #3;
    check("c1_instr_valid", 32'(instr_valid), 32'h0);
    cyc(); #3;
    check("c2_instr_valid", 32'(instr_valid), 32'h1);
    check("c2_instr_pc", 32'(instr_pc), 32'h0);
    check("c2_instr", 32'(instr), 32'h0001);
`ifdef FETCH_PERF_EN
    check("perf_stall_reset", 32'(perf_stall), 32'd2);
`endif
    cyc(); #3; check("c3_instr", 32'(instr), 32'h0005);
    cyc(); #3; check("c4_instr", 32'(instr), 32'h000b);
    cyc(); #3; check("c5_instr_pc", 32'(instr_pc), 32'h3);
    repeat (4) cyc();
`ifdef FETCH_PERF_EN
    #3; check("perf_fetched_ge5", 32'(perf_fetched >= 16'd5), 32'h1);
`endif

    // Backpressure: queue plus in-flight fill to DEPTH, then fetch holds.
    do_reset(1'b0);
    repeat (10) cyc();
    #3;
    check("stall_address_rom", 32'(address_rom), 32'd4);
    check("stall_head_pc", 32'({instr_valid, instr_pc}), 32'({1'b1, 16'h0000}));
    instr_ready = 1'b1;
    repeat (12) cyc();

    // Redirect with 3 queued entries and one in flight.
    do_reset(1'b0);
    repeat (4) cyc();
    redirect = 1'b1; redirect_pc = 16'h0040; load_expect(16'h0040);
    cyc();
    redirect = 1'b0; instr_ready = 1'b1;
    #3;
    check("redir_address_rom", 32'(address_rom), 32'h40);
    check("redir_t1_valid", 32'(instr_valid), 32'h0);
    cyc(); #3; check("redir_t2_valid", 32'(instr_valid), 32'h0);
    cyc(); #3;
    check("redir_t3_pc", 32'({instr_valid, instr_pc}), 32'({1'b1, 16'h0040}));
    check("redir_t3_instr", 32'(instr), 32'(rom[16'h0040]));
    repeat (6) cyc();

    // Redirect together with ready while full: nothing is popped.
    do_reset(1'b0);
    repeat (8) cyc();
    rp = 16'($urandom);
    redirect = 1'b1; redirect_pc = rp; instr_ready = 1'b1; load_expect(rp);
    cyc();
    redirect = 1'b0;
    repeat (2) cyc();
    #3; check("full_redir_pc", 32'({instr_valid, instr_pc}), 32'({1'b1, rp}));
    repeat (5) cyc();

    // Redirect near the top of the address space with ready held.
`ifdef FETCH_PERF_EN
    stall0 = perf_stall;
`endif
    redirect = 1'b1; redirect_pc = 16'hFFFE; load_expect(16'hFFFE);
    cyc();
    redirect = 1'b0;
    repeat (2) cyc();
    #3; check("wrap_pc0", 32'(instr_pc), 32'hFFFE);
`ifdef FETCH_PERF_EN
    check("perf_stall_redirect", 32'(perf_stall), 32'(stall0 + 16'd2));
`endif
    cyc(); #3; check("wrap_pc1", 32'(instr_pc), 32'hFFFF);
    cyc(); #3; check("wrap_pc2", 32'(instr_pc), 32'h0000);
    cyc(); #3; check("wrap_pc3", 32'(instr_pc), 32'h0001);

    // Random traffic: ready, redirects and occasional mid-stream resets.
    rst_cnt = 0;
    repeat (3000) begin
      cyc();
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) begin
          reset = 1'b0;
          load_expect(16'h0000);
        end
      end else if ($urandom_range(0, 999) < 4) begin
        reset = 1'b1; redirect = 1'b0; exp_q.delete();
        rst_cnt = $urandom_range(1, 3);
      end else begin
        redirect = ($urandom_range(0, 99) < 5);
        if (redirect) begin
          rp = 16'($urandom);
          redirect_pc = rp;
          load_expect(rp);
        end
      end
      instr_ready = ($urandom_range(0, 9) < 7);
    end
    cyc();
    redirect = 1'b0;
    if (reset) begin
      reset = 1'b0;
      load_expect(16'h0000);
    end
    instr_ready = 1'b1;
    repeat (20) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the stack-machine execute core. Drives the synchronous instruction ROM, buffers returned words in a small prefetch queue tagged with their addresses, and hands them to the core over a valid/ready handshake. The core redirects fetch on JMP/BRA/BEC/CALL/RET; a redirect flushes the queue and discards in-flight ROM data.

## Interface
- DEPTH, 4: prefetch queue entries; power of two, ≥2
- RESET_PC, 16'h0000: fetch address after reset
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- address_rom  out  16  ROM read address (registered fetch PC)
- q_rom  in  16  ROM data; valid one cycle after address presented
- redirect  in  1  core requests fetch restart
- redirect_pc  in  16  new fetch address, sampled when redirect=1
- instr  out  16  instruction word at queue head
- instr_pc  out  16  ROM address of instr
- instr_valid  out  1  head entry valid
- instr_ready  in  1  core accepts head this cycle
- perf_fetched, perf_stall  out  16 each  only with FETCH_PERF_EN

## Operation
- Registers: fetch_pc, req_valid (1-cycle in-flight flag), req_pc, queue (DEPTH × {pc, word}), count.
- address_rom = fetch_pc at all times.
- Issue: when count + req_valid < DEPTH and no redirect this cycle: req_valid←1, req_pc←fetch_pc, fetch_pc←fetch_pc+1 (mod 2^16, 16'hFFFF wraps to 16'h0000). Otherwise req_valid←0, fetch_pc holds.
- Return: when req_valid=1 and no redirect, {req_pc, q_rom} is pushed at the tail.
- Pop: instr_valid && instr_ready advances the head.
- Push and pop in the same cycle: count unchanged; legal when full.
- The issue rule guarantees no overflow; a push into a full queue is an assertion failure.
- Redirect (highest priority): queue cleared (count←0), req_valid←0 (pending ROM data discarded), fetch_pc←redirect_pc. Any instr_ready in the same cycle is ignored; the core treats its redirecting instruction as consumed.
- instr/instr_pc: combinational from the head entry. Hold their last value when empty; instr_valid=0.
- Reset values: fetch_pc=RESET_PC, address_rom=RESET_PC, req_valid=0, count=0, instr_valid=0, instr=0, instr_pc=0, perf counters 0.
- Reset mid-operation discards queue and in-flight data; no partial state survives.

## Timing
- Cycle 0 = first cycle with reset low: address_rom=RESET_PC issued.
- Cycle 1: q_rom pushed at the clock edge.
- Cycle 2: instr_valid=1, instr_pc=RESET_PC.
- Redirect asserted in cycle t: address_rom=redirect_pc in t+1; instr_valid=1 with instr_pc=redirect_pc in t+3. instr_valid=0 in t+1 and t+2.
- Steady state with instr_ready held high: one instruction per cycle, consecutive instr_pc.
- instr_ready low: queue fills to DEPTH (in-flight word counted), then address_rom holds.
- Resuming pops restarts issue the same cycle a slot frees.
- instr_valid must not drop while its entry is un-popped, except on redirect or reset.

## Configuration
- FETCH_PERF_EN defined:
  - perf_fetched counts words pushed into the queue.
  - perf_stall counts cycles with instr_ready=1 and instr_valid=0.
  - Both 16-bit, wrapping, cleared by reset.
- FETCH_PERF_EN undefined: both ports and counters absent; all other behaviour identical.

## Structure
- Shared package cpu_pkg:
  - WORD_W=16
  - opcode enum (IGN…NOT, 16'h0000–16'h0017), shared with the execute core
  - RESET_PC default
- Sub-module fetch_fifo: parameterised circular buffer (DEPTH, entry width 32).
  - Ports: push/pop/flush, head data, count.
  - Pointers wrap modulo DEPTH.
- instr_fetch holds the fetch-PC/in-flight logic.

## Test plan
- Reset release, ROM[0..3]=0001,0005,000b,0000, instr_ready=1 -> instr_valid from cycle 2; instr/instr_pc = (0001,0),(0005,1),(000b,2),(0000,3) on consecutive cycles.
- instr_ready=0 for 10 cycles, DEPTH=4 -> address_rom stops at 4. Queue holds pc 0–3. Release -> pcs 0,1,2,3,4… with no gap or duplicate.
- Redirect to 16'h0040 while queue holds 3 entries and a request is in flight -> instr_valid=0 for two cycles. Next instr_pc=0x40, instr=ROM[0x40]. No stale word delivered.
- Redirect and instr_ready asserted together with full queue -> queue flushed, no pop counted. First post-redirect instr_pc=redirect_pc.
- Redirect to 16'hFFFE, ready=1 -> instr_pc sequence FFFE, FFFF, 0000, 0001.
- With FETCH_PERF_EN: reset, 5 instructions consumed, one redirect -> perf_fetched≥5. perf_stall=2 at reset and +2 per redirect with ready held high.
